axi_mem_arbiter: RTL

- Shares the single 64-bit AXI4 memory port into the PS high-performance slave between two AXI4 masters, m0 and m1.
  - m0 is the Rocket io_mem_axi port.
  - m1 is a secondary DMA/debug master.
- AR and AW channels are arbitrated independently with round-robin grants.
- Each request carries its master index as the slave-side ID MSB, so B and R responses are routed back by ID with no response queue.
- Sits between Top and the system block's S_AXI port, in the host_clk domain.

---
 rtl/axi_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: shares one 64-bit AXI4 slave port between two AXI4 masters.
// AR and AW are arbitrated independently with round-robin grants. The granted
// master index is tagged into the slave-side ID MSB, so that B and R are routed
// back purely by ID.
// Optional feature macro: AXI_ARB_OUTSTANDING_LIMIT_EN. It caps outstanding
// reads and writes per master at MAX_OUT.
module axi_mem_arbiter #(
    parameter int ID_W    = 5,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int MAX_OUT = 4
) (
    input  logic                clock,
    input  logic                reset,
    // master 0
    input  logic                m0_aw_valid,
    output logic                m0_aw_ready,
    input  logic [ID_W-1:0]     m0_aw_bits_id,
    input  logic [ADDR_W-1:0]   m0_aw_bits_addr,
    input  logic [7:0]          m0_aw_bits_len,
    input  logic [2:0]          m0_aw_bits_size,
    input  logic [1:0]          m0_aw_bits_burst,
    input  logic                m0_w_valid,
    output logic                m0_w_ready,
    input  logic [DATA_W-1:0]   m0_w_bits_data,
    input  logic [DATA_W/8-1:0] m0_w_bits_strb,
    input  logic                m0_w_bits_last,
    output logic                m0_b_valid,
    input  logic                m0_b_ready,
    output logic [ID_W-1:0]     m0_b_bits_id,
    output logic [1:0]          m0_b_bits_resp,
    input  logic                m0_ar_valid,
    output logic                m0_ar_ready,
    input  logic [ID_W-1:0]     m0_ar_bits_id,
    input  logic [ADDR_W-1:0]   m0_ar_bits_addr,
    input  logic [7:0]          m0_ar_bits_len,
    input  logic [2:0]          m0_ar_bits_size,
    input  logic [1:0]          m0_ar_bits_burst,
    output logic                m0_r_valid,
    input  logic                m0_r_ready,
    output logic [ID_W-1:0]     m0_r_bits_id,
    output logic [DATA_W-1:0]   m0_r_bits_data,
    output logic [1:0]          m0_r_bits_resp,
    output logic                m0_r_bits_last,
    // master 1
    input  logic                m1_aw_valid,
    output logic                m1_aw_ready,
    input  logic [ID_W-1:0]     m1_aw_bits_id,
    input  logic [ADDR_W-1:0]   m1_aw_bits_addr,
    input  logic [7:0]          m1_aw_bits_len,
    input  logic [2:0]          m1_aw_bits_size,
    input  logic [1:0]          m1_aw_bits_burst,
    input  logic                m1_w_valid,
    output logic                m1_w_ready,
    input  logic [DATA_W-1:0]   m1_w_bits_data,
    input  logic [DATA_W/8-1:0] m1_w_bits_strb,
    input  logic                m1_w_bits_last,
    output logic                m1_b_valid,
    input  logic                m1_b_ready,
    output logic [ID_W-1:0]     m1_b_bits_id,
    output logic [1:0]          m1_b_bits_resp,
    input  logic                m1_ar_valid,
    output logic                m1_ar_ready,
    input  logic [ID_W-1:0]     m1_ar_bits_id,
    input  logic [ADDR_W-1:0]   m1_ar_bits_addr,
    input  logic [7:0]          m1_ar_bits_len,
    input  logic [2:0]          m1_ar_bits_size,
    input  logic [1:0]          m1_ar_bits_burst,
    output logic                m1_r_valid,
    input  logic                m1_r_ready,
    output logic [ID_W-1:0]     m1_r_bits_id,
    output logic [DATA_W-1:0]   m1_r_bits_data,
    output logic [1:0]          m1_r_bits_resp,
    output logic                m1_r_bits_last,
    // slave port
    output logic                s_aw_valid,
    input  logic                s_aw_ready,
    output logic [ID_W:0]       s_aw_bits_id,
    output logic [ADDR_W-1:0]   s_aw_bits_addr,
    output logic [7:0]          s_aw_bits_len,
    output logic [2:0]          s_aw_bits_size,
    output logic [1:0]          s_aw_bits_burst,
    output logic                s_w_valid,
    input  logic                s_w_ready,
    output logic [DATA_W-1:0]   s_w_bits_data,
    output logic [DATA_W/8-1:0] s_w_bits_strb,
    output logic                s_w_bits_last,
    input  logic                s_b_valid,
    output logic                s_b_ready,
    input  logic [ID_W:0]       s_b_bits_id,
    input  logic [1:0]          s_b_bits_resp,
    output logic                s_ar_valid,
    input  logic                s_ar_ready,
    output logic [ID_W:0]       s_ar_bits_id,
    output logic [ADDR_W-1:0]   s_ar_bits_addr,
    output logic [7:0]          s_ar_bits_len,
    output logic [2:0]          s_ar_bits_size,
    output logic [1:0]          s_ar_bits_burst,
    input  logic                s_r_valid,
    output logic                s_r_ready,
    input  logic [ID_W:0]       s_r_bits_id,
    input  logic [DATA_W-1:0]   s_r_bits_data,
    input  logic [1:0]          s_r_bits_resp,
    input  logic                s_r_bits_last
);

    typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;
    typedef enum logic [1:0] {AW_IDLE, AW_ADDR, AW_DATA} aw_state_t;

    ar_state_t ar_state_q, ar_state_d;
    logic      ar_grant_q, ar_grant_d;
    logic      ar_ptr_q,   ar_ptr_d;
    aw_state_t aw_state_q, aw_state_d;
    logic      aw_grant_q, aw_grant_d;
    logic      aw_ptr_q,   aw_ptr_d;

    // Per-master arbitration exclusion (outstanding limit reached).
    logic [1:0] rd_block, wr_block;
    logic [1:0] ar_req, aw_req;

    // Response selectors come straight from the tagged ID MSB.
    logic b_sel, r_sel;
    assign b_sel = s_b_bits_id[ID_W];
    assign r_sel = s_r_bits_id[ID_W];

    assign ar_req = {m1_ar_valid & ~rd_block[1], m0_ar_valid & ~rd_block[0]};
    assign aw_req = {m1_aw_valid & ~wr_block[1], m0_aw_valid & ~wr_block[0]};

    // Payloads follow the registered grant. Only valid/ready are state-gated.
    assign s_ar_bits_id    = {ar_grant_q, ar_grant_q ? m1_ar_bits_id : m0_ar_bits_id};
    assign s_ar_bits_addr  = ar_grant_q ? m1_ar_bits_addr  : m0_ar_bits_addr;
    assign s_ar_bits_len   = ar_grant_q ? m1_ar_bits_len   : m0_ar_bits_len;
    assign s_ar_bits_size  = ar_grant_q ? m1_ar_bits_size  : m0_ar_bits_size;
    assign s_ar_bits_burst = ar_grant_q ? m1_ar_bits_burst : m0_ar_bits_burst;

    assign s_aw_bits_id    = {aw_grant_q, aw_grant_q ? m1_aw_bits_id : m0_aw_bits_id};
    assign s_aw_bits_addr  = aw_grant_q ? m1_aw_bits_addr  : m0_aw_bits_addr;
    assign s_aw_bits_len   = aw_grant_q ? m1_aw_bits_len   : m0_aw_bits_len;
    assign s_aw_bits_size  = aw_grant_q ? m1_aw_bits_size  : m0_aw_bits_size;
    assign s_aw_bits_burst = aw_grant_q ? m1_aw_bits_burst : m0_aw_bits_burst;

    assign s_w_bits_data   = aw_grant_q ? m1_w_bits_data : m0_w_bits_data;
    assign s_w_bits_strb   = aw_grant_q ? m1_w_bits_strb : m0_w_bits_strb;
    assign s_w_bits_last   = aw_grant_q ? m1_w_bits_last : m0_w_bits_last;

    // B routing: stateless demux on the ID MSB.
    assign m0_b_valid     = s_b_valid & ~b_sel;
    assign m1_b_valid     = s_b_valid &  b_sel;
    assign m0_b_bits_id   = s_b_bits_id[ID_W-1:0];
    assign m1_b_bits_id   = s_b_bits_id[ID_W-1:0];
    assign m0_b_bits_resp = s_b_bits_resp;
    assign m1_b_bits_resp = s_b_bits_resp;
    assign s_b_ready      = b_sel ? m1_b_ready : m0_b_ready;

    // R routing: same scheme as B.
    assign m0_r_valid     = s_r_valid & ~r_sel;
    assign m1_r_valid     = s_r_valid &  r_sel;
    assign m0_r_bits_id   = s_r_bits_id[ID_W-1:0];
    assign m1_r_bits_id   = s_r_bits_id[ID_W-1:0];
    assign m0_r_bits_data = s_r_bits_data;
    assign m1_r_bits_data = s_r_bits_data;
    assign m0_r_bits_resp = s_r_bits_resp;
    assign m1_r_bits_resp = s_r_bits_resp;
    assign m0_r_bits_last = s_r_bits_last;
    assign m1_r_bits_last = s_r_bits_last;
    assign s_r_ready      = r_sel ? m1_r_ready : m0_r_ready;

    // AR arbitration: pick a master in IDLE, forward its request in BUSY.
    always_comb begin
        ar_state_d  = ar_state_q;
        ar_grant_d  = ar_grant_q;
        ar_ptr_d    = ar_ptr_q;
        s_ar_valid  = 1'b0;
        m0_ar_ready = 1'b0;
        m1_ar_ready = 1'b0;
        case (ar_state_q)
            AR_IDLE: begin
                if (|ar_req) begin
                    ar_grant_d = (&ar_req) ? ar_ptr_q : ar_req[1];
                    ar_state_d = AR_BUSY;
                end
            end
            AR_BUSY: begin
                s_ar_valid  = ar_grant_q ? m1_ar_valid : m0_ar_valid;
                m0_ar_ready = s_ar_ready & ~ar_grant_q;
                m1_ar_ready = s_ar_ready &  ar_grant_q;
                if (s_ar_valid && s_ar_ready) begin
                    ar_state_d = AR_IDLE;
                    ar_ptr_d   = ~ar_grant_q;
                end
            end
            default: ar_state_d = AR_IDLE;
        endcase
    end

    // AW arbitration: the grant is held through the whole W burst, which keeps W in AW order.
    always_comb begin
        aw_state_d  = aw_state_q;
        aw_grant_d  = aw_grant_q;
        aw_ptr_d    = aw_ptr_q;
        s_aw_valid  = 1'b0;
        m0_aw_ready = 1'b0;
        m1_aw_ready = 1'b0;
        s_w_valid   = 1'b0;
        m0_w_ready  = 1'b0;
        m1_w_ready  = 1'b0;
        case (aw_state_q)
            AW_IDLE: begin
                if (|aw_req) begin
                    aw_grant_d = (&aw_req) ? aw_ptr_q : aw_req[1];
                    aw_state_d = AW_ADDR;
                end
            end
            AW_ADDR: begin
                s_aw_valid  = aw_grant_q ? m1_aw_valid : m0_aw_valid;
                m0_aw_ready = s_aw_ready & ~aw_grant_q;
                m1_aw_ready = s_aw_ready &  aw_grant_q;
                if (s_aw_valid && s_aw_ready) begin
                    aw_state_d = AW_DATA;
                end
            end
            AW_DATA: begin
                s_w_valid  = aw_grant_q ? m1_w_valid : m0_w_valid;
                m0_w_ready = s_w_ready & ~aw_grant_q;
                m1_w_ready = s_w_ready &  aw_grant_q;
                if (s_w_valid && s_w_ready && s_w_bits_last) begin
                    aw_state_d = AW_IDLE;
                    aw_ptr_d   = ~aw_grant_q;
                end
            end
            default: aw_state_d = AW_IDLE;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ar_state_q <= AR_IDLE;
            ar_grant_q <= 1'b0;
            ar_ptr_q   <= 1'b0;
            aw_state_q <= AW_IDLE;
            aw_grant_q <= 1'b0;
            aw_ptr_q   <= 1'b0;
        end else begin
            ar_state_q <= ar_state_d;
            ar_grant_q <= ar_grant_d;
            ar_ptr_q   <= ar_ptr_d;
            aw_state_q <= aw_state_d;
            aw_grant_q <= aw_grant_d;
            aw_ptr_q   <= aw_ptr_d;
        end
    end

`ifdef AXI_ARB_OUTSTANDING_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0] rd_out_q [2];
    logic [CNT_W-1:0] rd_out_d [2];
    logic [CNT_W-1:0] wr_out_q [2];
    logic [CNT_W-1:0] wr_out_d [2];

    // Outstanding counters: +1 on address handshake, -1 on final response.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            logic rd_inc, rd_dec, wr_inc, wr_dec;
            rd_inc = s_ar_valid & s_ar_ready & (ar_grant_q == 1'(n));
            rd_dec = s_r_valid & s_r_ready & s_r_bits_last & (r_sel == 1'(n));
            wr_inc = s_aw_valid & s_aw_ready & (aw_grant_q == 1'(n));
            wr_dec = s_b_valid & s_b_ready & (b_sel == 1'(n));
            rd_out_d[n] = rd_out_q[n];
            wr_out_d[n] = wr_out_q[n];
            if (rd_inc && !rd_dec) rd_out_d[n] = rd_out_q[n] + 1'b1;
            if (!rd_inc && rd_dec) rd_out_d[n] = rd_out_q[n] - 1'b1;
            if (wr_inc && !wr_dec) wr_out_d[n] = wr_out_q[n] + 1'b1;
            if (!wr_inc && wr_dec) wr_out_d[n] = wr_out_q[n] - 1'b1;
            rd_block[n] = (rd_out_q[n] == CNT_W'(MAX_OUT));
            wr_block[n] = (wr_out_q[n] == CNT_W'(MAX_OUT));
        end
    end

    // Outstanding counter registers.
    always_ff @(posedge clock) begin
        for (int n = 0; n < 2; n++) begin
            if (reset) begin
                rd_out_q[n] <= '0;
                wr_out_q[n] <= '0;
            end else begin
                rd_out_q[n] <= rd_out_d[n];
                wr_out_q[n] <= wr_out_d[n];
            end
        end
    end
`else
    assign rd_block = 2'b00;
    assign wr_block = 2'b00;
`endif

endmodule
